// File: rtl/nibble_serial_addsub.sv
// Serial 32-bit adder/subtractor: one nibble per clock through a 4-bit
// operand-select mux and a 4-bit adder slice with a registered carry.

module mux2x1_4b (
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic       select,
    output logic [3:0] y
);
    assign y = select ? d1 : d0;
endmodule

module nibble_serial_addsub (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ready,
    output logic        done,
    output logic [31:0] result,
    output logic        carry,
    output logic        overflow,
    output logic        zero
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        op_q, op_d;
    logic        creg_q, creg_d;
    logic [31:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        overflow_q, overflow_d;
    logic        zero_q, zero_d;

    logic [3:0]  b_inv;
    logic [3:0]  b_n;
    logic [4:0]  sum5;

    assign b_inv = ~b_q[3:0];

    mux2x1_4b u_bsel (
        .d0     (b_q[3:0]),
        .d1     (b_inv),
        .select (op_q),
        .y      (b_n)
    );

    // Subtraction is A + ~B + 1; the +1 comes from seeding the carry with op.
    assign sum5 = {1'b0, a_q[3:0]} + {1'b0, b_n} + {4'b0000, creg_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        creg_d     = creg_q;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = 3'd0;
                    creg_d  = op;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d = {sum5[3:0], result_q[31:4]};
                a_d      = {4'b0000, a_q[31:4]};
                b_d      = {4'b0000, b_q[31:4]};
                creg_d   = sum5[4];
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    // Last nibble: a_q[3] and b_n[3] are the sign bits of A and effective B.
                    carry_d    = sum5[4];
                    overflow_d = (a_q[3] == b_n[3]) && (sum5[3] != a_q[3]);
                    zero_d     = (result_d == 32'h0);
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            a_q        <= 32'h0;
            b_q        <= 32'h0;
            op_q       <= 1'b0;
            creg_q     <= 1'b0;
            result_q   <= 32'h0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            creg_q     <= creg_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Multi-cycle 32-bit adder/subtractor that consumes operands 4 bits per clock. It is built around the `mux2x1_4b` datapath slice and sits directly downstream of it.
- Each cycle, a `mux2x1_4b` instance selects the B nibble or its complement, driven by `op`.
- A 4-bit adder slice with a registered carry consumes that nibble.
- A full result plus flags is produced after eight nibble steps.

This is the serial add/sub stage the 32-bit ALU uses when area is preferred over single-cycle latency.

## Interface
Parameters: none. Width is fixed at 32 bits, processed as 8 nibbles.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only when `ready`=1.
- `op`  in  1  0 = add (A+B), 1 = subtract (A−B).
- `a`  in  32  operand A; captured on an accepted `start`.
- `b`  in  32  operand B; captured on an accepted `start`.
- `ready`  out  1  block idle, able to accept `start`.
- `done`  out  1  one-cycle pulse: result and flags valid and new.
- `result`  out  32  sum or difference.
- `carry`  out  1  carry out of bit 31. For subtract this is the no-borrow flag: 1 means A ≥ B unsigned.
- `overflow`  out  1  signed overflow.
- `zero`  out  1  `result` == 0.

## Operation
State machine with three states:
- IDLE: `ready`=1.
  - `start`=1 → latch `a`, `b`, `op` into internal shift registers; nibble counter=0; carry register=`op`; go to RUN.
  - `start`=0 → stay in IDLE.
- RUN: each edge processes one nibble, LSB nibble first.
  - b_n = `op` ? ~B[3:0] : B[3:0], via the `mux2x1_4b` slice, with `select`=`op`.
  - {c, s} = A[3:0] + b_n + carry_reg.
  - s shifts into `result` from the top: result <= {s, result[31:4]}.
  - A and B shift right by 4; carry_reg <= c; counter increments.
  - On the edge where counter==7, go to DONE.
- DONE: `done`=1 for exactly this cycle; `ready`=0. The next edge goes to IDLE.

Flags are registered on the edge that processes nibble 7:
- `carry` = final c.
- `overflow` = (a31 == b_eff31) && (r31 != a31). Here b_eff31 = b31 ^ `op`, using the latched operands.
- `zero` = (final result == 0).

Hold and ignore rules:
- `result` and flags hold their values from DONE through IDLE until the next accepted `start`.
- During RUN they may show partial values; consumers use them only when `done`=1 or thereafter.
- `start` asserted in RUN or DONE is ignored: no queuing, no restart.
- Changes on `a`, `b`, `op` after acceptance have no effect.
- Arithmetic is modulo 2^32; there is no saturation.

## Timing
- Reset values: state=IDLE, `ready`=1, `done`=0, `result`=32'h0, `carry`=0, `overflow`=0, `zero`=0, counter=0.
- `rst` overrides everything, including mid-RUN and in DONE. The aborted operation produces no `done`.
- Latency: `start` is sampled at edge E0. RUN covers cycles 1–8 (edges E1–E8). `done`=1 in cycle 9. `ready`=1 again in cycle 10, so a new `start` can be accepted at E10.
- Throughput: one operation per 10 cycles when back-to-back.
- `ready` is 0 from the cycle after acceptance through the DONE cycle inclusive.
- `done` never asserts for two consecutive cycles.

## Test plan
1. Reset held 2 cycles, then released → `ready`=1, `done`=0, `result`=0, all flags 0. Stays idle with `start`=0.
2. Add: `start`, `op`=0, a=32'h0000000F, b=32'h00000001.
   - `done` exactly 9 cycles after the accept edge.
   - `result`=32'h00000010, C=0, V=0, Z=0.
3. Add wrap: a=32'hFFFFFFFF, b=32'h00000001 → `result`=0, C=1, Z=1, V=0. Then a=32'h7FFFFFFF, b=1 → 32'h80000000, V=1, C=0.
4. Subtract:
   - 32'h80000000 − 1 → 32'h7FFFFFFF, C=1, V=1, Z=0.
   - 5 − 5 → 0, C=1, Z=1.
   - 3 − 5 → 32'hFFFFFFFE, C=0, V=0.
5. Protocol:
   - `start` pulsed again during RUN with different operands → ignored. The first result completes unchanged, with one `done` pulse.
   - Back-to-back `start` held high → second operation accepted at E10.
   - `a`/`b` changed after the accept edge → no effect on the result.
6. Mid-operation reset: assert `rst` in RUN cycle 4 → next cycle is IDLE with all outputs at reset values and no `done`. A following add of 2+3 yields 5 normally.
